// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// led_pkg : shared LED-128 tables, GF(16) helpers, FSM and command encodings
// Rev 1.0
// ============================================================================
package led_pkg;

  localparam logic [5:0] RC_LAST = 6'h04;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDKEY0   = 4'd1,
    ST_INVMIX    = 4'd2,
    ST_MIXROT    = 4'd3,
    ST_INVSHIFT  = 4'd4,
    ST_INVSUB    = 4'd5,
    ST_NEXTROUND = 4'd6,
    ST_ADDKEY    = 4'd7,
    ST_NEXTSTEP  = 4'd8
  } ctl_state_t;

  typedef enum logic [3:0] {
    CMD_IDLE        = 4'd0,
    CMD_LOADKEY     = 4'd1,
    CMD_LOADCT      = 4'd2,
    CMD_GETPT       = 4'd3,
    CMD_ADDKEY      = 4'd4,
    CMD_ADDKEY_LAST = 4'd5,
    CMD_MIXCOMP     = 4'd6,
    CMD_MIXROT      = 4'd7,
    CMD_INVSHIFT    = 4'd8,
    CMD_INVSUB      = 4'd9,
    CMD_NEXTROUND   = 4'd10,
    CMD_HOLD        = 4'd11
  } cmd_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // GF(16) modulo x^4+x+1
  function automatic logic [3:0] gf_mul2(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] gf_mul4(input logic [3:0] a);
    return gf_mul2(gf_mul2(a));
  endfunction

  function automatic logic [3:0] gf_mul13(input logic [3:0] a);
    return gf_mul2(gf_mul4(a)) ^ gf_mul4(a) ^ a;
  endfunction

  // Round-constant nibble for row-major position n (key-size bits fixed at 128)
  function automatic logic [3:0] rc_const(input logic [3:0] n, input logic [5:0] rc);
    logic [3:0] c;
    c = 4'h0;
    case (n[1:0])
      2'd0: begin
        case (n[3:2])
          2'd0:    c = 4'h8;
          2'd1:    c = 4'h9;
          2'd2:    c = 4'h2;
          default: c = 4'h3;
        endcase
      end
      2'd1:    c = {1'b0, (n[2] ? rc[2:0] : rc[5:3])};
      default: c = 4'h0;
    endcase
    return c;
  endfunction

  function automatic int nib_lsb(input int row, input int col);
    return (15 - (4 * row + col)) * 4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_dec_ctrl.sv
`default_nettype none
// ============================================================================
// led_dec_ctrl : LED-128 decryption sequencer, issues one datapath command/cycle
// Rev 1.0
// ============================================================================
module led_dec_ctrl
  import led_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_loadkey,
  input  logic       i_loadct,
  input  logic       i_getpt,
  input  logic       i_start,
  output cmd_t       o_cmd,
  output logic [3:0] o_bcount,
  output logic       o_done
);

  ctl_state_t r_ctlstate, w_next;
  logic [3:0] r_bcount, r_rcount, r_scount;
  logic [3:0] w_bcount_nxt, w_rcount_nxt, w_scount_nxt;
  cmd_t       w_cmd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ctlstate <= ST_IDLE;
      r_bcount   <= 4'd0;
      r_rcount   <= 4'd0;
      r_scount   <= 4'd0;
    end else begin
      r_ctlstate <= w_next;
      r_bcount   <= w_bcount_nxt;
      r_rcount   <= w_rcount_nxt;
      r_scount   <= w_scount_nxt;
    end
  end

  always_comb begin
    w_next       = r_ctlstate;
    w_cmd        = CMD_HOLD;
    w_bcount_nxt = r_bcount;
    w_rcount_nxt = r_rcount;
    w_scount_nxt = r_scount;
    case (r_ctlstate)
      ST_IDLE: begin
        w_bcount_nxt = 4'd0;
        w_rcount_nxt = 4'd0;
        w_scount_nxt = 4'd0;
        if (i_loadkey)     w_cmd = CMD_LOADKEY;
        else if (i_loadct) w_cmd = CMD_LOADCT;
        else if (i_getpt)  w_cmd = CMD_GETPT;
        else               w_cmd = CMD_IDLE;
        if (i_start) w_next = ST_ADDKEY0;
      end
      ST_ADDKEY0: begin
        w_cmd        = CMD_ADDKEY;
        w_bcount_nxt = r_bcount + 4'd1;
        if (r_bcount == 4'd15) w_next = ST_INVMIX;
      end
      // bcount counts the 16 column computes; it wraps to 0 after the last column
      ST_INVMIX: begin
        w_cmd        = CMD_MIXCOMP;
        w_bcount_nxt = r_bcount + 4'd1;
        if (r_bcount[1:0] == 2'd3) w_next = ST_MIXROT;
      end
      ST_MIXROT: begin
        w_cmd  = CMD_MIXROT;
        w_next = (r_bcount == 4'd0) ? ST_INVSHIFT : ST_INVMIX;
      end
      ST_INVSHIFT: begin
        w_cmd  = CMD_INVSHIFT;
        w_next = ST_INVSUB;
      end
      ST_INVSUB: begin
        w_cmd        = CMD_INVSUB;
        w_bcount_nxt = r_bcount + 4'd1;
        if (r_bcount == 4'd15) w_next = ST_NEXTROUND;
      end
      ST_NEXTROUND: begin
        w_cmd = CMD_NEXTROUND;
        if (r_rcount == 4'd3) begin
          w_rcount_nxt = 4'd0;
          w_next       = ST_ADDKEY;
        end else begin
          w_rcount_nxt = r_rcount + 4'd1;
          w_next       = ST_INVMIX;
        end
      end
      ST_ADDKEY: begin
        w_cmd        = (r_scount == 4'd11) ? CMD_ADDKEY_LAST : CMD_ADDKEY;
        w_bcount_nxt = r_bcount + 4'd1;
        if (r_bcount == 4'd15) w_next = ST_NEXTSTEP;
      end
      ST_NEXTSTEP: begin
        if (r_scount == 4'd11) begin
          w_scount_nxt = 4'd0;
          w_next       = ST_IDLE;
        end else begin
          w_scount_nxt = r_scount + 4'd1;
          w_next       = ST_INVMIX;
        end
      end
      default: begin
        w_next       = ST_IDLE;
        w_bcount_nxt = 4'd0;
        w_rcount_nxt = 4'd0;
        w_scount_nxt = 4'd0;
      end
    endcase
  end

  assign o_cmd    = w_cmd;
  assign o_bcount = r_bcount;
  assign o_done   = (r_ctlstate == ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/led_serial_dec.sv
`default_nettype none
// ============================================================================
// led_serial_dec : nibble-serial LED-128 decryption core with bit-serial I/O
// Rev 1.0
// ============================================================================
module led_serial_dec
  import led_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic keyi,
  input  logic datai,
  output logic dataq,
  input  logic loadkey,
  input  logic loadct,
  input  logic getpt,
  input  logic start,
  output logic done
);

  logic [63:0]  r_state;
  logic [127:0] r_key;
  logic [5:0]   r_rc;

  cmd_t        w_cmd;
  logic [3:0]  w_bcount;
  logic [3:0]  w_mix;
  logic [63:0] w_state_mix, w_state_rot, w_state_shift;

  led_dec_ctrl u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .i_loadkey (loadkey),
    .i_loadct  (loadct),
    .i_getpt   (getpt),
    .i_start   (start),
    .o_cmd     (w_cmd),
    .o_bcount  (w_bcount),
    .o_done    (done)
  );

  assign w_mix = gf_mul13(r_state[15:12] ^ r_state[63:60] ^
                          gf_mul2(r_state[47:44]) ^ gf_mul2(r_state[31:28]));

  always_comb begin
    w_state_rot   = r_state;
    w_state_shift = r_state;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        w_state_rot[nib_lsb(i, j) +: 4]   = r_state[nib_lsb(i, (j + 1) % 4) +: 4];
        w_state_shift[nib_lsb(i, j) +: 4] = r_state[nib_lsb(i, (j + 4 - i) % 4) +: 4];
      end
    end
    w_state_mix        = r_state;
    w_state_mix[63:60] = w_mix;
    w_state_mix[47:44] = r_state[63:60];
    w_state_mix[31:28] = r_state[47:44];
    w_state_mix[15:12] = r_state[31:28];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= '0;
      r_key   <= '0;
      r_rc    <= RC_LAST;
    end else begin
      case (w_cmd)
        CMD_IDLE: r_rc <= RC_LAST;
        CMD_LOADKEY: begin
          r_key <= {r_key[126:0], keyi};
          r_rc  <= RC_LAST;
        end
        CMD_LOADCT: begin
          r_state <= {r_state[62:0], datai};
          r_rc    <= RC_LAST;
        end
        CMD_GETPT: begin
          r_state <= {r_state[62:0], 1'b0};
          r_rc    <= RC_LAST;
        end
        CMD_ADDKEY: begin
          r_state <= {r_state[59:0], r_state[63:60] ^ r_key[127:124]};
          r_key   <= {r_key[123:0], r_key[127:124]};
        end
        // Thirteen AddKeys would leave the halves swapped; the final one spins
        // only the upper half so the key is back to its loaded value at the end.
        CMD_ADDKEY_LAST: begin
          r_state <= {r_state[59:0], r_state[63:60] ^ r_key[127:124]};
          r_key   <= {r_key[123:64], r_key[127:124], r_key[63:0]};
        end
        CMD_MIXCOMP:  r_state <= w_state_mix;
        CMD_MIXROT:   r_state <= w_state_rot;
        CMD_INVSHIFT: r_state <= w_state_shift;
        CMD_INVSUB: begin
          r_state <= {r_state[59:0], inv_sbox(r_state[63:60]) ^ rc_const(w_bcount, r_rc)};
        end
        CMD_NEXTROUND: r_rc <= {1'b1 ^ r_rc[0] ^ r_rc[5], r_rc[5:1]};
        default: ;
      endcase
    end
  end

  assign dataq = r_state[63];

endmodule
`default_nettype wire

// File: doc/led_serial_dec.md
LED_SERIAL_DEC -- requirements
Module: led_serial_dec

Interface
REQ-001 Parameters: none; the block is fixed to LED-128 (64-bit block, 128-bit key, 12 steps of 4 rounds).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 keyi  input  1  serial key bit, MSB first.
REQ-005 datai  input  1  serial ciphertext bit, MSB first.
REQ-006 dataq  output  1  serial plaintext bit; equals state[63].
REQ-007 loadkey  input  1  shift keyi into key while idle.
REQ-008 loadct  input  1  shift datai into state while idle.
REQ-009 getpt  input  1  shift state out while idle.
REQ-010 start  input  1  begin decryption when sampled in IDLE.
REQ-011 done  output  1  high exactly when the FSM is in IDLE.

Function
REQ-012 Internal registers: state[63:0]; key[127:0]; rc[5:0]; bcount, rcount, scount, 4 bits each. Nibble (i,j) is state[(15-(4i+j))*4 +: 4], so (0,0) is the MSBs.
REQ-013 IDLE command priority: loadkey > loadct > getpt.
  - loadkey: key <= {key[126:0], keyi}.
  - loadct: state <= {state[62:0], datai}.
  - getpt: state <= {state[62:0], 1'b0}.
REQ-014 In every IDLE cycle: rc <= RC_LAST (6'h04); all counters clear. start=1 moves to ADDKEY0 in the same cycle any load command executes.
REQ-015 ADDKEY (16 cycles):
  - new (3,3) = (0,0) XOR key[127:124]; all other nibbles shift toward (0,0) in row-major order.
  - key rotates left by 4 bits each cycle, so successive AddKeys use alternating key halves, starting with key[127:64].
REQ-016 Step sequence after ADDKEY0: 4 rounds, then ADDKEY (16 cycles), then NEXTSTEP (1 cycle), repeated 12 times, then IDLE.
REQ-017 Round = INVMIX (20 cycles) -> INVSHIFT (1) -> INVSUB (16) -> NEXTROUND (1); 38 cycles total.
REQ-018 INVMIX per column: 4 compute cycles then 1 column-rotate cycle, repeated for 4 columns.
  - Compute: (0,0) <= 13*((3,0)^(0,0)^2*(1,0)^2*(2,0)), (1,0) <= (0,0), (2,0) <= (1,0), (3,0) <= (2,0).
  - Arithmetic is GF(16) modulo x^4+x+1.
  - Rotate: every row rotates left by one column.
REQ-019 INVSHIFT: row r rotates right by r positions, e.g. (1,0) <= (1,3), (1,1) <= (1,0).
REQ-020 INVSUB: new (3,3) = invSbox((0,0)) XOR C(bcount); other nibbles shift as in ADDKEY.
  - invSbox = inverse of {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2}.
  - C(n) for n=0..15: 8,rc[5:3],0,0, 9,rc[2:0],0,0, 2,rc[5:3],0,0, 3,rc[2:0],0,0.
REQ-021 NEXTROUND: rc <= {1^rc[0]^rc[5], rc[5:1]} (inverse of the encryption LFSR); after the 4th round, go to ADDKEY.
REQ-022 Latency: with start sampled at edge T0, done is low for exactly 2044 cycles, and the plaintext is valid in state when done returns high.
REQ-023 While busy, loadkey/loadct/getpt/start are ignored and key is modified only by the ADDKEY rotation.
  - key returns to its loaded value at completion, so back-to-back decryptions need no reload.
REQ-024 Illegal FSM encodings go to IDLE on the next cycle.

Reset
REQ-025 reset=0 at a clock edge forces, on that edge, regardless of other inputs:
  - ctlstate=IDLE, state=0, key=0, rc=RC_LAST, all counters 0;
  - outputs done=1, dataq=0.
REQ-026 Reset mid-decryption aborts the operation; no partial result is retained.

Structure
REQ-027 Shared package led_pkg holds:
  - Sbox and inverse-Sbox tables, RC_LAST, the C(n) constant decode;
  - GF(16) multiply-by-2/4/13 functions;
  - FSM state and command encodings shared with the encryption core.
REQ-028 Control FSM and counters live in one sub-module, led_dec_ctrl, which drives a command code to the datapath in led_serial_dec.

Verification
REQ-029 Key=0, ciphertext 64'h3DECB2A0850CDBA1, start -> after 2044 cycles, getpt shifts out 64'h0.
REQ-030 Key=128'h0123456789ABCDEF0123456789ABCDEF, ciphertext 64'hA003551E3893FC58 -> plaintext 64'h0123456789ABCDEF.
REQ-031 Round-trip: 100 random key/plaintext pairs, encrypted by the encryption core then decrypted -> the original plaintext every time.
REQ-032 Second decryption without reloading the key -> correct result; rc observed as 6'h04 at the first INVSUB cycle.
REQ-033 reset=0 at cycle 1000 of a decryption -> done=1 next cycle, state=0; a fresh load plus start then yields the correct plaintext.
REQ-034 start/loadct/loadkey toggled while done=0 -> no effect on the result; loadkey and loadct both high in IDLE -> only key shifts.
